// File: rtl/modadd_seq.sv
// Modular add/subtract sequencer: drives a multi-precision adder for one or two
// passes and owns the conditional correction step.
module modadd_seq #(
    parameter int unsigned W = 1027
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_m,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         adder_start,
    output logic         adder_subtract,
    output logic [W-1:0] adder_in_a,
    output logic [W-1:0] adder_in_b,
    input  logic [W:0]   adder_result,
    input  logic         adder_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ST1  = 3'd1,
        S_WT1  = 3'd2,
        S_ST2  = 3'd3,
        S_WT2  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_mode;
    logic [W-1:0]   r_m;
    logic [W-1:0]   r_t;
    logic [W-1:0]   r_result;
    logic           r_done;
    logic           r_busy;
    logic           r_adder_start;
    logic           r_adder_subtract;
    logic [W-1:0]   r_adder_in_a;
    logic [W-1:0]   r_adder_in_b;

    logic           w_mode_nxt;
    logic [W-1:0]   w_m_nxt;
    logic [W-1:0]   w_t_nxt;
    logic [W-1:0]   w_result_nxt;
    logic           w_done_nxt;
    logic           w_busy_nxt;
    logic           w_adder_start_nxt;
    logic           w_adder_subtract_nxt;
    logic [W-1:0]   w_adder_in_a_nxt;
    logic [W-1:0]   w_adder_in_b_nxt;

    logic [W-1:0]   w_sum;
    logic           w_flag;
    logic           w_skip;

    assign w_sum  = adder_result[W-1:0];
    assign w_flag = adder_result[W];
    // Subtract with no borrow is already reduced, so pass 2 is skipped.
    assign w_skip = r_mode && !w_flag;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_ST1;
            S_ST1:  w_state_nxt = S_WT1;
            S_WT1:  if (adder_done) w_state_nxt = w_skip ? S_FIN : S_ST2;
            S_ST2:  w_state_nxt = S_WT2;
            S_WT2:  if (adder_done) w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        w_mode_nxt           = r_mode;
        w_m_nxt              = r_m;
        w_t_nxt              = r_t;
        w_result_nxt         = r_result;
        w_adder_subtract_nxt = r_adder_subtract;
        w_adder_in_a_nxt     = r_adder_in_a;
        w_adder_in_b_nxt     = r_adder_in_b;
        w_done_nxt           = (w_state_nxt == S_FIN);
        w_busy_nxt           = (w_state_nxt != S_IDLE);
        w_adder_start_nxt    = (w_state_nxt == S_ST1) || (w_state_nxt == S_ST2);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_nxt           = mode;
                    w_m_nxt              = in_m;
                    w_adder_in_a_nxt     = in_a;
                    w_adder_in_b_nxt     = in_b;
                    w_adder_subtract_nxt = mode;
                end
            end
            S_WT1: begin
                if (adder_done) begin
                    w_t_nxt = w_sum;
                    if (w_skip) begin
                        w_result_nxt = w_sum;
                    end else begin
                        // Pass 2 flips the operation: add -> t-M, subtract -> t+M.
                        w_adder_in_a_nxt     = w_sum;
                        w_adder_in_b_nxt     = r_m;
                        w_adder_subtract_nxt = !r_mode;
                    end
                end
            end
            S_WT2: begin
                if (adder_done) begin
                    w_result_nxt = (!r_mode && w_flag) ? r_t : w_sum;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mode           <= 1'b0;
            r_m              <= '0;
            r_t              <= '0;
            r_result         <= '0;
            r_done           <= 1'b0;
            r_busy           <= 1'b0;
            r_adder_start    <= 1'b0;
            r_adder_subtract <= 1'b0;
            r_adder_in_a     <= '0;
            r_adder_in_b     <= '0;
        end else begin
            r_mode           <= w_mode_nxt;
            r_m              <= w_m_nxt;
            r_t              <= w_t_nxt;
            r_result         <= w_result_nxt;
            r_done           <= w_done_nxt;
            r_busy           <= w_busy_nxt;
            r_adder_start    <= w_adder_start_nxt;
            r_adder_subtract <= w_adder_subtract_nxt;
            r_adder_in_a     <= w_adder_in_a_nxt;
            r_adder_in_b     <= w_adder_in_b_nxt;
        end
    end

    assign result         = r_result;
    assign done           = r_done;
    assign busy           = r_busy;
    assign adder_start    = r_adder_start;
    assign adder_subtract = r_adder_subtract;
    assign adder_in_a     = r_adder_in_a;
    assign adder_in_b     = r_adder_in_b;

endmodule

// File: tb/tb_modadd_seq.sv
// Directed bench for modadd_seq with a two-cycle-latency behavioural adder.
module tb_modadd_seq;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         mode;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_m;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         adder_start;
    logic         adder_subtract;
    logic [W-1:0] adder_in_a;
    logic [W-1:0] adder_in_b;
    logic [W:0]   adder_result = '0;
    logic         adder_done = 1'b0;
    logic         r_p1 = 1'b0;

    int total = 0;
    int bad   = 0;

    modadd_seq #(.W(W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .mode           (mode),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_m           (in_m),
        .result         (result),
        .done           (done),
        .busy           (busy),
        .adder_start    (adder_start),
        .adder_subtract (adder_subtract),
        .adder_in_a     (adder_in_a),
        .adder_in_b     (adder_in_b),
        .adder_result   (adder_result),
        .adder_done     (adder_done)
    );

    always #5 clk = ~clk;

    // Adder model, L = 2: done two cycles after adder_start, operands held meanwhile.
    always @(posedge clk) begin
        r_p1       <= adder_start;
        adder_done <= r_p1;
        if (adder_subtract)
            adder_result <= {1'b0, adder_in_a} - {1'b0, adder_in_b};
        else
            adder_result <= {1'b0, adder_in_a} + {1'b0, adder_in_b};
    end

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Cycle 0 = start high; returns result, done cycle (0 = timeout), adder_start count.
    task automatic run_op(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input bit glitch,
                          output logic [W-1:0] res, output int cyc, output int nst,
                          output logic busy1);
        @(negedge clk);
        start = 1'b1; mode = md; in_a = a; in_b = b; in_m = m;
        cyc = 0; nst = 0; res = '0; busy1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (glitch && (c == 2 || c == 3)) begin
                start = 1'b1; mode = 1'b1; in_a = 64'd1; in_b = 64'd2; in_m = 64'd3;
            end
            if (c == 1) busy1 = busy;
            if (adder_start) nst++;
            if (done) begin
                cyc = c;
                res = result;
                break;
            end
        end
        start = 1'b0;
    endtask

    // Assert reset in cycle k of an add op, then check cleanup and stray adder_done.
    task automatic reset_mid(input int k);
        logic stray;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; in_a = 64'd5; in_b = 64'd7; in_m = 64'd11;
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == k) resetn = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("rst%0d_busy", k), 64'(busy), 64'd0);
        chk($sformatf("rst%0d_done", k), 64'(done), 64'd0);
        chk($sformatf("rst%0d_result", k), result, 64'd0);
        chk($sformatf("rst%0d_astart", k), 64'(adder_start), 64'd0);
        resetn = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) stray = 1'b1;
        end
        chk($sformatf("rst%0d_stray", k), 64'(stray), 64'd0);
    endtask

    typedef struct {
        string        nm;
        logic         md;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic [W-1:0] exp_res;
        int           exp_cyc;
        int           exp_nst;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] big_m;
        int           cyc;
        int           nst;
        logic         busy1;

        big_m = '1;
        big_m[W-1] = 1'b0;
        vecs[0] = '{"add_corr",  1'b0, 64'd5, 64'd7, 64'd11, 64'd1, 7, 2};
        vecs[1] = '{"add_nocorr",1'b0, 64'd3, 64'd4, 64'd11, 64'd7, 7, 2};
        vecs[2] = '{"add_zero",  1'b0, 64'd4, 64'd7, 64'd11, 64'd0, 7, 2};
        vecs[3] = '{"add_big",   1'b0, big_m - 64'd1, big_m - 64'd1, big_m, big_m - 64'd2, 7, 2};
        vecs[4] = '{"sub_corr",  1'b1, 64'd3, 64'd7, 64'd11, 64'd7, 7, 2};
        vecs[5] = '{"sub_skip",  1'b1, 64'd7, 64'd3, 64'd11, 64'd4, 4, 1};
        vecs[6] = '{"sub_eq",    1'b1, 64'd9, 64'd9, 64'd11, 64'd0, 4, 1};

        resetn = 1'b0; start = 1'b0; mode = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_astart", 64'(adder_start), 64'd0);
        chk("reset_ina", adder_in_a, 64'd0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].m, 1'b0, res, cyc, nst, busy1);
            chk({vecs[i].nm, "_result"}, res, vecs[i].exp_res);
            chk({vecs[i].nm, "_cycle"}, 64'(cyc), 64'(vecs[i].exp_cyc));
            chk({vecs[i].nm, "_nstart"}, 64'(nst), 64'(vecs[i].exp_nst));
            chk({vecs[i].nm, "_busy1"}, 64'(busy1), 64'd1);
            @(negedge clk);
            chk({vecs[i].nm, "_hold"}, result, vecs[i].exp_res);
            chk({vecs[i].nm, "_done_pulse"}, 64'(done), 64'd0);
        end

        // Start pulses during an operation must not disturb it or queue a new one.
        run_op(1'b0, 64'd5, 64'd7, 64'd11, 1'b1, res, cyc, nst, busy1);
        chk("glitch_result", res, 64'd1);
        chk("glitch_cycle", 64'(cyc), 64'd7);
        @(negedge clk);
        chk("glitch_idle", 64'(busy), 64'd0);

        reset_mid(3);
        reset_mid(5);

        run_op(1'b1, 64'd3, 64'd7, 64'd11, 1'b0, res, cyc, nst, busy1);
        chk("fresh_result", res, 64'd7);
        chk("fresh_cycle", 64'(cyc), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modadd_seq.md
# modadd_seq

Sequencer that computes modular addition or subtraction, (a + b) mod M or (a − b) mod M, by driving the team's multi-precision adder (start/subtract/in_a/in_b → result/done) over its initiator side. It replaces the ad-hoc add-then-conditionally-subtract sequencing in the exponentiation datapath. It issues one or two adder passes per operation and owns the correction decision.

## Interface
Parameters:
- W, 1027: operand width; adder result width is W+1.

Ports:
- clk  in  1  the single clock.
- resetn  in  1  active-low reset, synchronous to clk.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = modular add, 1 = modular subtract; latched at start.
- in_a  in  W  operand a, 0 ≤ a < M; latched at start.
- in_b  in  W  operand b, 0 ≤ b < M; latched at start.
- in_m  in  W  modulus M, 0 < M < 2^(W−1); latched at start.
- result  out  W  modular result, valid while done = 1 and held until the next start.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after start is accepted until done.
- adder_start  out  1  one-cycle pulse to the adder.
- adder_subtract  out  1  adder operation select.
- adder_in_a  out  W  adder operand A.
- adder_in_b  out  W  adder operand B.
- adder_result  in  W+1  adder result. Bit W is the carry for an add and the borrow flag for a subtract: 1 means the difference is negative.
- adder_done  in  1  adder completion pulse.

## Operation
- Reset: all outputs are 0 and the state is IDLE.
- States:
  - IDLE: in this state, start = 1 latches mode, a, b and M, then moves to ST1.
  - ST1: drives the pass-1 operands with adder_start = 1, then moves to WT1.
  - WT1: holds the pass-1 operands. On adder_done it captures t = adder_result[W−1:0] and the flag f = adder_result[W]. It then moves to ST2, except in subtract mode with f = 0, where it moves to FIN with result = t.
  - ST2: drives the pass-2 operands with adder_start = 1, then moves to WT2.
  - WT2: holds the pass-2 operands. On adder_done it selects the result (rules below) and moves to FIN.
  - FIN: done = 1 for one cycle, then returns to IDLE.
- Add mode:
  - Pass 1 is a + b with adder_subtract = 0. The sum is < 2M < 2^W, so bit W = 0.
  - Pass 2 is t − M with adder_subtract = 1.
  - If the borrow flag = 1, result = t. Otherwise result = adder_result[W−1:0].
- Subtract mode:
  - Pass 1 is a − b with adder_subtract = 1.
  - If f = 0, result = t and pass 2 is skipped.
  - Otherwise pass 2 is t + M with adder_subtract = 0, and result = adder_result[W−1:0]. This sum wraps mod 2^W, and bit W is ignored.
- adder_in_a, adder_in_b and adder_subtract stay stable from ST1/ST2 until the matching adder_done is captured. The adder pipeline requires this.
- Outside ST1/ST2, adder_start = 0.
- adder_done outside WT1/WT2 is ignored.
- start while busy = 1 is ignored, and the latched operands are unchanged.
- resetn = 0 in any state takes effect at the next edge: IDLE, done = 0, adder_start = 0, result = 0. The in-flight adder pass is abandoned, and its late adder_done is ignored in IDLE.
- result changes only on the edge entering FIN or on reset.

## Timing
- Cycle 0 is start high in IDLE. L is the number of cycles from adder_start high to adder_done high; the team adder has L = 2.
- Two-pass path:
  - adder_start high in cycles 1 and 2+L.
  - done high in cycle 3+2L, which is cycle 7 for L = 2.
- Skip path (subtract mode, no borrow): done high in cycle 2+L, which is cycle 4.
- busy is high from cycle 1 through the done cycle inclusive.
- A new start is accepted in the cycle after done, so operations can run back to back.
- No combinational path exists from any input to any output.

## Test plan
- Add with correction: M = 11, a = 5, b = 7 → two passes, result = 1, done in cycle 7.
- Add without correction: M = 11, a = 3, b = 4 → pass 2 reports borrow, result = 7, done in cycle 7.
- Add boundary: M = 11, a = 4, b = 7 → result = 0. Also a = b = M−1 with M = 2^(W−1)−1 → result = M−2.
- Subtract with correction: M = 11, a = 3, b = 7 → result = 7, done in cycle 7.
- Subtract with skip: M = 11, a = 7, b = 3 → result = 4, one adder_start pulse, done in cycle 4. Also a = b = 9 → result = 0 with skip.
- Robustness:
  - start pulsed in cycles 2 and 3 during an operation → ignored, and the first result is correct.
  - resetn = 0 in cycle 3 → next cycle has IDLE, done = 0, result = 0, and the stray adder_done produces no done.
  - A fresh operation afterwards returns the correct result.
